seq_restoring_div_4bit: RTL and testbench
=========================================

Name: seq_restoring_div_4bit

Overview:
- Sequential unsigned restoring divider that sits directly downstream of the 4-bit ripple-borrow subtractor.
- Each iteration it computes a trial subtraction of partial remainder minus divisor (borrow chain), then keeps or restores the partial remainder based on the final borrow.
- Produces quotient and remainder over WIDTH cycles with a start/busy/done handshake.
- Used wherever the arithmetic library needs division without a combinational array divider.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is not busy.
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
- busy  output  1  high while an iteration sequence is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- quotient  output  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  output  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy, done, quotient, remainder and div_by_zero all clear to 0.
  - The internal iteration counter clears.
  - Reset overrides everything, including a start in the same cycle.
  - Reset mid-operation abandons the calculation; no done is produced.
- States:
  - IDLE: busy=0, done=0. start=1 captures the operands, then:
    - divisor==0: go to DONE.
    - otherwise: go to CALC. The partial remainder R (WIDTH+1 bits) clears to 0, the quotient shift register is loaded with dividend, and the counter is set to WIDTH.
  - CALC: busy=1. Once per cycle:
    - R' = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left by one.
    - Trial T = R' - {0,divisor} as a WIDTH+1-bit borrow-ripple subtraction with borrow-in 0.
    - Borrow-out 0: R=T and the new Q LSB is 1.
    - Borrow-out 1: R=R' (restore) and the new Q LSB is 0.
    - The counter decrements. When the counter reaches 0 after this iteration, go to DONE.
    - start is ignored throughout CALC.
  - DONE (exactly one cycle): done=1, busy=0.
    - Normal case: quotient=Q and remainder=R[WIDTH-1:0].
    - Divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1.
    - Next state is IDLE, except that start=1 in DONE is accepted exactly as in IDLE, which allows back-to-back operations.
- Latency:
  - Start accepted at edge N: busy is high for cycles N+1 through N+WIDTH, and done is high in cycle N+WIDTH+1. For WIDTH=4, done arrives 5 cycles after start.
  - Divide by zero: done is high in cycle N+1 and busy never rises.
- Outputs:
  - quotient, remainder and div_by_zero update only on entry to DONE.
  - They keep their values through IDLE and through the following CALC until the next DONE.
  - div_by_zero clears on the next non-zero-divisor DONE.
- Arithmetic:
  - Operation is purely unsigned.
  - Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.
  - The WIDTH+1-bit R never overflows.
- Inputs: dividend and divisor may change freely after the start cycle without affecting the result.

Test Plan:
- Reset, then dividend=13, divisor=3, start pulse → busy high 4 cycles; done in cycle 5 with quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 → quotient=15, remainder=0. dividend=2, divisor=3 → quotient=0, remainder=2. dividend=0, divisor=5 → quotient=0, remainder=0.
- dividend=7, divisor=0 → done 1 cycle after start, busy stays 0, quotient=15, remainder=7, div_by_zero=1. Then 9/4 → quotient=2, remainder=1, div_by_zero=0.
- Start 13/3; pulse start with 15/15 during cycle 2 of busy → ignored; result is quotient=4, remainder=1, and only one done occurs.
- Start 12/5; assert rst in cycle 2 of busy → next cycle all outputs are 0 and no done appears. Then start 12/5 → quotient=2, remainder=2.
- Back-to-back: start 14/4, then hold start with 11/2 in the done cycle → first done gives quotient=3, remainder=2; second done follows 5 cycles later with quotient=5, remainder=1. Also run an exhaustive 16×16 sweep checking the invariant.

Source files
------------

// File: rtl/seq_restoring_div_4bit.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle through a
// ripple-borrow chain, with a start/busy/done handshake.

module seq_restoring_div_4bit_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module seq_restoring_div_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] brw;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             unused;

  // The remainder never reaches 2^WIDTH, so the top bit of R drops out of the shift.
  assign rem_sh = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign sub_b  = {1'b0, dvs_r};
  assign brw[0] = 1'b0;
  assign unused = rem_r[WIDTH];

  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      seq_restoring_div_4bit_fs u_fs (
        .a    (rem_sh[i]),
        .b    (sub_b[i]),
        .bin  (brw[i]),
        .d    (trial[i]),
        .bout (brw[i+1])
      );
    end
  endgenerate

  // Final borrow set: trial went negative, restore the shifted remainder.
  assign rem_nxt = brw[WIDTH+1] ? rem_sh : trial;
  assign quo_nxt = {quo_r[WIDTH-2:0], ~brw[WIDTH+1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start) begin
            dvs_r <= divisor;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              rem_r <= '0;
              quo_r <= dividend;
              cnt   <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_div_4bit.sv
// Scoreboard bench for seq_restoring_div_4bit: directed plan, exhaustive sweep, random traffic.
module tb_seq_restoring_div_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dz;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0, errors = 0, cyc = 0;
  int   last_q = 0, last_r = 0, last_dz = 0;
  bit   mon_en = 1'b0;

  seq_restoring_div_4bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every done against the queued reference and checks busy/hold each cycle.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("busy", int'(busy),
          int'(sb.size() != 0 && !sb[0].dz && cyc < sb[0].due));
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
        end else begin
          me = sb.pop_front();
          chk("quotient", int'(quotient), me.q);
          chk("remainder", int'(remainder), me.r);
          chk("div_by_zero", int'(div_by_zero), int'(me.dz));
          chk("done_cycle", cyc, me.due);
          if (!me.dz) begin
            chk("invariant", int'(quotient) * me.b + int'(remainder), me.a);
            chk("rem_lt_div", int'(int'(remainder) < me.b), 1);
          end
          last_q = me.q; last_r = me.r; last_dz = int'(me.dz);
        end
      end else begin
        chk("hold", (int'(quotient) << 8) | (int'(remainder) << 1) | int'(div_by_zero),
            (last_q << 8) | (last_r << 1) | last_dz);
      end
    end
  end

  // Drives start for one edge, then queues the reference result computed with / and %.
  task automatic issue(input int a, input int b);
    exp_t e;
    start = 1'b1; dividend = a[W-1:0]; divisor = b[W-1:0];
    @(posedge clk); #1;
    e.a = a; e.b = b; e.dz = (b == 0);
    e.q = (b == 0) ? (1 << W) - 1 : a / b;
    e.r = (b == 0) ? a : a % b;
    e.due = cyc + ((b == 0) ? 0 : W);
    sb.push_back(e);
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout_idle actual=%0d expected=0 pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout_done actual=0 expected=1");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    last_q = 0; last_r = 0; last_dz = 0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    issue(13, 3); wait_idle();
    issue(15, 1); wait_idle();
    issue(2, 3);  wait_idle();
    issue(0, 5);  wait_idle();
    issue(7, 0);  wait_idle();
    issue(9, 4);  wait_idle();

    // start during the second busy cycle must be ignored
    issue(13, 3);
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // reset in the middle of a calculation abandons it
    issue(12, 5);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    repeat (8) @(negedge clk);
    issue(12, 5); wait_idle();

    // back-to-back: second start held during the done cycle
    issue(14, 4); wait_done();
    issue(11, 2); wait_idle();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        issue(a, b); wait_idle();
      end

    for (int k = 0; k < 200; k++) begin
      issue(int'($urandom_range(15)), ($urandom_range(7) == 0) ? 0 : int'($urandom_range(15)));
      if ($urandom_range(1) == 1) wait_done();
      else wait_idle();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
